// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// buffers each fetched {pc, instruction} pair in a small FIFO that feeds the
// decode stage.
//
// Decode handshake: id_valid_o is high whenever the queue holds an entry.
// The head entry is consumed on a rising edge where id_valid_o and
// id_ready_i are both high, unless a branch redirect is taken on that edge.
// id_ready_i has no effect while the queue is empty. id_valid_o, id_pc_o and
// id_inst_o depend only on registered state.
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_ce,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Registered state.
  logic              ce_q;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  // Queue storage; contents are only observable while count_q != 0.
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic push;
  logic pop;

  // Branch targets are forced word-aligned, so the low two bits are dropped.
  logic unused_target_low_bits;
  assign unused_target_low_bits = ^branch_target_i[1:0];

  // The ROM is enabled only when the queue has room; the decision uses
  // registered state so decode/branch inputs never reach inst_ce/inst_addr.
  assign inst_ce    = ce_q && (count_q < DEPTH_C);
  assign inst_addr  = pc_q;

  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = id_valid_o ? pc_mem_q[rd_ptr_q]   : '0;
  assign id_inst_o  = id_valid_o ? inst_mem_q[rd_ptr_q] : '0;

  // A branch edge suppresses both push and pop: the fetched word is
  // wrong-path and the head entry is being discarded anyway.
  assign push = inst_ce && !branch_flag_i;
  assign pop  = id_valid_o && id_ready_i && !branch_flag_i;

  // Next-state: branch flush has priority, otherwise normal push/pop update.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (branch_flag_i) begin
      pc_d     = {branch_target_i[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control registers; ce_q comes up on the first edge after reset release,
  // so that cycle issues no fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q     <= 1'b0;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      ce_q     <= 1'b1;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Capture the accepted ROM word together with the PC that fetched it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a table of per-cycle expected outputs and
// inputs, followed by a hand-written asynchronous reset sequence.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int checks = 0;
  int errors = 0;

  if_fetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_ce         (inst_ce),
    .inst_addr       (inst_addr),
    .inst_i          (inst_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .id_ready_i      (id_ready_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word at byte address a is 0xA000_0000 + a/4, combinational.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign inst_i = rom_word(inst_addr);

  // One row per cycle: expected outputs of the cycle, then inputs driven
  // for the edge that ends the cycle.
  typedef struct {
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [31:0] p, input logic ce,
                     input logic [31:0] a, input logic rdy, input logic br,
                     input logic [31:0] tgt);
    vec_t r;
    r.exp_valid = v;  r.exp_pc = p;  r.exp_ce = ce;  r.exp_addr = a;
    r.ready = rdy;    r.br = br;     r.tgt = tgt;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic v, input logic [31:0] p,
                               input logic ce, input logic [31:0] a);
    chk("id_valid", row, {31'd0, id_valid_o}, {31'd0, v});
    chk("id_pc",    row, id_pc_o,   v ? p : 32'h0);
    chk("id_inst",  row, id_inst_o, v ? rom_word(p) : 32'h0);
    chk("inst_ce",  row, {31'd0, inst_ce}, {31'd0, ce});
    chk("inst_addr", row, inst_addr, a);
  endtask

  initial begin
    rst             = 1'b1;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    id_ready_i      = 1'b0;

    //  valid  head_pc        ce    addr           ready br   target
    add(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0);        // r0 just released
    add(1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h0);        // r1 first fetch
    add(1'b1, 32'h0,         1'b1, 32'h4,         1'b1, 1'b0, 32'h0);        // r2 streaming
    add(1'b1, 32'h4,         1'b1, 32'h8,         1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h8,         1'b1, 32'hC,         1'b1, 1'b0, 32'h0);
    add(1'b1, 32'hC,         1'b1, 32'h10,        1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h10,        1'b1, 32'h14,        1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h14,        1'b1, 32'h18,        1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h18,        1'b1, 32'h1C,        1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h1C,        1'b1, 32'h20,        1'b1, 1'b0, 32'h0);        // r9
    add(1'b1, 32'h20,        1'b1, 32'h24,        1'b0, 1'b1, 32'h0);        // r10 branch to 0
    add(1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0);        // r11 flushed
    add(1'b1, 32'h0,         1'b1, 32'h4,         1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h0,         1'b0, 32'h8,         1'b0, 1'b0, 32'h0);        // r13 full, stalled
    add(1'b1, 32'h0,         1'b0, 32'h8,         1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h0,         1'b0, 32'h8,         1'b1, 1'b0, 32'h0);        // r15 pop while full
    add(1'b1, 32'h4,         1'b1, 32'h8,         1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h8,         1'b1, 32'hC,         1'b1, 1'b0, 32'h0);
    add(1'b1, 32'hC,         1'b1, 32'h10,        1'b0, 1'b0, 32'h0);
    add(1'b1, 32'hC,         1'b0, 32'h14,        1'b1, 1'b1, 32'h0000_0103); // r19 full + branch
    add(1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h100,       1'b1, 32'h104,       1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h104,       1'b1, 32'h108,       1'b1, 1'b1, 32'hFFFF_FFF0); // r22 branch
    add(1'b0, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'hFFFF_FFFE); // r23 back-to-back
    add(1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    add(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0);        // r25 wrapped
    add(1'b1, 32'h0,         1'b1, 32'h4,         1'b0, 1'b0, 32'h0);        // r26

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      #1;
      check_outputs(i, vq[i].exp_valid, vq[i].exp_pc, vq[i].exp_ce, vq[i].exp_addr);
      id_ready_i      = vq[i].ready;
      branch_flag_i   = vq[i].br;
      branch_target_i = vq[i].tgt;
      @(negedge clk);
    end

    // Queue now holds 0x0 and 0x4; assert reset between edges.
    branch_flag_i = 1'b0;
    id_ready_i    = 1'b0;
    #1;
    check_outputs(100, 1'b1, 32'h0, 1'b0, 32'h8);
    #1;
    rst = 1'b1;
    #1;
    check_outputs(101, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs(102, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    check_outputs(103, 1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    check_outputs(104, 1'b1, 32'h0, 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
